servo_pwm_multi: RTL and testbench

SERVO_PWM_MULTI -- requirements
Module: servo_pwm_multi

---
 rtl/servo_pkg.sv | 29 ++
 rtl/servo_channel.sv | 67 ++++++
 rtl/servo_pwm_multi.sv | 92 +++++++++
 tb/tb_servo_pwm_multi.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared constants and width helpers for the multi-channel servo PWM block.
package servo_pkg;

  localparam int unsigned PosW = 8;

  localparam int unsigned DefNumCh       = 4;
  localparam int unsigned DefFrameCycles = 1000000;
  localparam int unsigned DefMinCycles   = 50000;
  localparam int unsigned DefStepCycles  = 195;
  localparam int unsigned DefSlewStep    = 255;
  localparam int unsigned DefResetPos    = 128;

  function automatic int unsigned ch_width(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned frame_cycles);
    return (frame_cycles > 2) ? $clog2(frame_cycles) : 1;
  endfunction

  // Wide enough for the longest pulse, MIN + STEP * 255.
  function automatic int unsigned limit_width(input int unsigned min_cycles,
                                              input int unsigned step_cycles);
    int unsigned max_lim;
    max_lim = min_cycles + step_cycles * 255;
    return (max_lim > 0) ? $clog2(max_lim + 1) : 1;
  endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo channel: position target, per-frame slew, pulse-width latch and output compare.
module servo_channel
  import servo_pkg::*;
#(
  parameter int unsigned CNT_W       = 10,
  parameter int unsigned LIM_W       = 10,
  parameter int unsigned MIN_CYCLES  = 100,
  parameter int unsigned STEP_CYCLES = 2,
  parameter int unsigned SLEW_STEP   = 255,
  parameter int unsigned RESET_POS   = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [PosW-1:0]  wr_pos,
  input  logic             frame_tick,
  input  logic [CNT_W-1:0] count,
  input  logic             ch_en,
  output logic             pwm
);

  localparam int unsigned CMP_W = (CNT_W > LIM_W) ? CNT_W : LIM_W;
  localparam logic [8:0] Slew9 = 9'(SLEW_STEP);
  localparam logic [LIM_W-1:0] LimReset = LIM_W'(MIN_CYCLES + STEP_CYCLES * RESET_POS);

  logic [PosW-1:0]  target_q;
  logic [PosW-1:0]  cur_q, cur_d;
  logic             en_q;
  logic [LIM_W-1:0] limit_q, limit_d;
  logic [8:0]       sum, gap;

  // Slew toward the target with 9-bit headroom so neither direction wraps.
  always_comb begin
    cur_d = cur_q;
    sum   = {1'b0, cur_q} + Slew9;
    gap   = '0;
    if (cur_q < target_q) begin
      cur_d = (sum >= {1'b0, target_q}) ? target_q : sum[7:0];
    end else if (cur_q > target_q) begin
      gap   = {1'b0, cur_q} - {1'b0, target_q};
      cur_d = (gap <= Slew9) ? target_q : cur_q - Slew9[7:0];
    end
    limit_d = LIM_W'(MIN_CYCLES) + LIM_W'(STEP_CYCLES) * LIM_W'(cur_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= PosW'(RESET_POS);
      cur_q    <= PosW'(RESET_POS);
      en_q     <= 1'b0;
      limit_q  <= LimReset;
      pwm      <= 1'b0;
    end else begin
      if (wr_en) begin
        target_q <= wr_pos;
      end
      if (frame_tick) begin
        cur_q   <= cur_d;
        en_q    <= ch_en;
        limit_q <= limit_d;
      end
      // On the wrap edge count is FRAME-1 > limit, so frames never bleed into each other.
      pwm <= en_q && (CMP_W'(count) < CMP_W'(limit_q));
    end
  end

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator: shared frame counter and write decode,
// one servo_channel per output.
module servo_pwm_multi
  import servo_pkg::*;
#(
  parameter int unsigned NUM_CH       = DefNumCh,
  parameter int unsigned FRAME_CYCLES = DefFrameCycles,
  parameter int unsigned MIN_CYCLES   = DefMinCycles,
  parameter int unsigned STEP_CYCLES  = DefStepCycles,
  parameter int unsigned SLEW_STEP    = DefSlewStep,
  parameter int unsigned RESET_POS    = DefResetPos,
  localparam int unsigned CH_W        = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [PosW-1:0]   wr_pos,
  output logic              wr_err,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              frame_start
);

  localparam int unsigned CNT_W = cnt_width(FRAME_CYCLES);
  localparam int unsigned LIM_W = limit_width(MIN_CYCLES, STEP_CYCLES);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(FRAME_CYCLES - 1);

  if (MIN_CYCLES + STEP_CYCLES * 255 >= FRAME_CYCLES) begin : gen_bad_frame
    $error("servo_pwm_multi: longest pulse does not fit in the frame");
  end
  if (SLEW_STEP == 0 || SLEW_STEP > 255) begin : gen_bad_slew
    $error("servo_pwm_multi: SLEW_STEP must be 1..255");
  end

  logic [CNT_W-1:0]  count_q, count_d;
  logic              wrap;
  logic              accept;
  logic              ch_ok;
  logic              wr_err_q;
  logic              frame_start_q;
  logic [NUM_CH-1:0] wr_en;

  assign wrap   = (count_q == CntLast);
  assign ch_ok  = (32'(wr_ch) < NUM_CH);
  // Writes are blocked on the boundary cycle so a target never races the slew update.
  assign wr_ready = rst_n && !wrap;
  assign accept   = wr_valid && wr_ready;

  always_comb begin
    count_d = wrap ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q       <= '0;
      wr_err_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      count_q       <= count_d;
      wr_err_q      <= accept && !ch_ok;
      frame_start_q <= wrap;
    end
  end

  assign wr_err      = wr_err_q;
  assign frame_start = frame_start_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
    assign wr_en[i] = accept && (wr_ch == CH_W'(i));

    servo_channel #(
      .CNT_W       (CNT_W),
      .LIM_W       (LIM_W),
      .MIN_CYCLES  (MIN_CYCLES),
      .STEP_CYCLES (STEP_CYCLES),
      .SLEW_STEP   (SLEW_STEP),
      .RESET_POS   (RESET_POS)
    ) u_channel (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_en[i]),
      .wr_pos     (wr_pos),
      .frame_tick (wrap),
      .count      (count_q),
      .ch_en      (ch_en[i]),
      .pwm        (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench: dut a (4 ch, no slew limit) and dut b (5 ch, slew 16) share clock and reset.
module tb_servo_pwm_multi;

  logic clk = 1'b0;
  logic rst_n;

  logic       wr_valid_a, wr_ready_a, wr_err_a, fs_a;
  logic [1:0] wr_ch_a;
  logic [7:0] wr_pos_a;
  logic [3:0] ch_en_a, pwm_a;

  logic       wr_valid_b, wr_ready_b, wr_err_b, fs_b;
  logic [2:0] wr_ch_b;
  logic [7:0] wr_pos_b;
  logic [4:0] ch_en_b, pwm_b;

  int n_tests = 0;
  int n_fail  = 0;
  int tb_cnt;
  int acc_a[4], wid_a[4], acc_b[5], wid_b[5];

  always #5 clk = ~clk;

  servo_pwm_multi #(
    .NUM_CH       (4),
    .FRAME_CYCLES (1000),
    .MIN_CYCLES   (100),
    .STEP_CYCLES  (2)
  ) u_dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_valid    (wr_valid_a),
    .wr_ready    (wr_ready_a),
    .wr_ch       (wr_ch_a),
    .wr_pos      (wr_pos_a),
    .wr_err      (wr_err_a),
    .ch_en       (ch_en_a),
    .pwm_out     (pwm_a),
    .frame_start (fs_a)
  );

  servo_pwm_multi #(
    .NUM_CH       (5),
    .FRAME_CYCLES (1000),
    .MIN_CYCLES   (100),
    .STEP_CYCLES  (2),
    .SLEW_STEP    (16)
  ) u_dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_valid    (wr_valid_b),
    .wr_ready    (wr_ready_b),
    .wr_ch       (wr_ch_b),
    .wr_pos      (wr_pos_b),
    .wr_err      (wr_err_b),
    .ch_en       (ch_en_b),
    .pwm_out     (pwm_b),
    .frame_start (fs_b)
  );

  // Reference frame counter: value the DUT counter should hold in the current cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cnt <= 0;
    else        tb_cnt <= (tb_cnt == 999) ? 0 : tb_cnt + 1;
  end

  // Pulse-width monitor: wid_* holds the high-cycle count of the previous frame.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin acc_a[i] <= 0; wid_a[i] <= 0; end
      for (int i = 0; i < 5; i++) begin acc_b[i] <= 0; wid_b[i] <= 0; end
    end else if (fs_a) begin
      for (int i = 0; i < 4; i++) begin wid_a[i] <= acc_a[i]; acc_a[i] <= int'(pwm_a[i]); end
      for (int i = 0; i < 5; i++) begin wid_b[i] <= acc_b[i]; acc_b[i] <= int'(pwm_b[i]); end
    end else begin
      for (int i = 0; i < 4; i++) acc_a[i] <= acc_a[i] + int'(pwm_a[i]);
      for (int i = 0; i < 5; i++) acc_b[i] <= acc_b[i] + int'(pwm_b[i]);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the negedge (+1) of the cycle whose counter value is v.
  task automatic wait_cnt(input int v);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      #1;
      guard++;
    end while (tb_cnt != v && guard < 2100);
  endtask

  task automatic write_a(input logic [1:0] ch, input logic [7:0] pos);
    wr_valid_a = 1'b1; wr_ch_a = ch; wr_pos_a = pos;
    @(negedge clk); #1;
    wr_valid_a = 1'b0;
  endtask

  task automatic write_b(input logic [2:0] ch, input logic [7:0] pos);
    wr_valid_b = 1'b1; wr_ch_b = ch; wr_pos_b = pos;
    @(negedge clk); #1;
    wr_valid_b = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    wr_valid_a = 1'b0; wr_ch_a = '0; wr_pos_a = '0; ch_en_a = 4'hF;
    wr_valid_b = 1'b0; wr_ch_b = '0; wr_pos_b = '0; ch_en_b = 5'h1F;
    repeat (3) @(negedge clk);
    #1;
    check("rst_pwm_a", 32'(pwm_a), 0);
    check("rst_pwm_b", 32'(pwm_b), 0);
    check("rst_ready", 32'(wr_ready_a), 0);
    check("rst_fs", 32'(fs_a), 0);
    check("rst_err", 32'(wr_err_a), 0);

    rst_n = 1'b1;
    #1;
    check("rel_ready", 32'(wr_ready_a), 1);
    check("rel_fs_at_0", 32'(fs_a), 0);
    wait_cnt(999);
    check("ready_low_last", 32'(wr_ready_a), 0);
    wait_cnt(0);
    check("fs_first_wrap", 32'(fs_a), 1);
    for (int i = 0; i < 4; i++) check($sformatf("f0_wid_a%0d", i), wid_a[i], 0);
    check("f0_wid_b0", wid_b[0], 0);
    wait_cnt(1);
    check("fs_one_cycle", 32'(fs_a), 0);
    wait_cnt(0);
    for (int i = 0; i < 4; i++) check($sformatf("f1_wid_a%0d", i), wid_a[i], 356);
    for (int i = 0; i < 5; i++) check($sformatf("f1_wid_b%0d", i), wid_b[i], 356);

    // Mid-frame write applies from the next frame; no slew limit on dut a.
    wait_cnt(500);
    write_a(2'd2, 8'd255);
    wait_cnt(0);
    check("ch2_same_frame", wid_a[2], 356);
    wait_cnt(500);
    write_a(2'd2, 8'd0);
    wait_cnt(0);
    check("ch2_pos255", wid_a[2], 610);
    check("ch1_untouched", wid_a[1], 356);
    wait_cnt(0);
    check("ch2_pos0", wid_a[2], 100);

    // Write held across the boundary cycle is only taken at counter 0.
    wait_cnt(999);
    wr_valid_a = 1'b1; wr_ch_a = 2'd0; wr_pos_a = 8'd0;
    check("hold_ready_last", 32'(wr_ready_a), 0);
    wait_cnt(0);
    check("hold_ready_0", 32'(wr_ready_a), 1);
    @(negedge clk); #1;
    wr_valid_a = 1'b0;
    wait_cnt(0);
    check("hold_ch0_cur", wid_a[0], 356);
    wait_cnt(0);
    check("hold_ch0_next", wid_a[0], 100);

    // Enable drop mid-pulse: pulse completes, then silence.
    wait_cnt(50);
    check("en_mid_pulse", 32'(pwm_a[1]), 1);
    ch_en_a = 4'b1101;
    wait_cnt(0);
    check("en_drop_cur", wid_a[1], 356);
    wait_cnt(0);
    check("en_drop_next", wid_a[1], 0);
    check("en_other", wid_a[3], 356);

    // Out-of-range channel on dut b.
    wait_cnt(300);
    write_b(3'd5, 8'd0);
    check("err_pulse", 32'(wr_err_b), 1);
    @(negedge clk); #1;
    check("err_one_cycle", 32'(wr_err_b), 0);
    check("err_a_quiet", 32'(wr_err_a), 0);
    wait_cnt(0);
    wait_cnt(0);
    for (int i = 0; i < 5; i++) check($sformatf("err_wid_b%0d", i), wid_b[i], 356);

    // Slew-limited descent on dut b ch0.
    wait_cnt(500);
    write_b(3'd0, 8'd0);
    wait_cnt(0);
    check("slew_f0", wid_b[0], 356);
    for (int k = 1; k <= 8; k++) begin
      wait_cnt(0);
      check($sformatf("slew_f%0d", k), wid_b[0], 356 - 32 * k);
    end
    wait_cnt(0);
    check("slew_settled", wid_b[0], 100);
    check("slew_ch1", wid_b[1], 356);

    // Reset during a pulse clears outputs asynchronously.
    wait_cnt(200);
    check("pre_rst_pwm", 32'(pwm_a[3]), 1);
    rst_n = 1'b0;
    #1;
    check("async_pwm_a", 32'(pwm_a), 0);
    check("async_pwm_b", 32'(pwm_b), 0);
    check("async_ready", 32'(wr_ready_a), 0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rerel_fs", 32'(fs_a), 0);
    wait_cnt(0);
    check("rerel_fs_wrap", 32'(fs_a), 1);
    for (int i = 0; i < 4; i++) check($sformatf("rerel_f0_a%0d", i), wid_a[i], 0);
    wait_cnt(0);
    check("rerel_f1_a0", wid_a[0], 356);
    check("rerel_f1_a1", wid_a[1], 0);
    check("rerel_f1_a2", wid_a[2], 356);
    check("rerel_f1_a3", wid_a[3], 356);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
